// File: rtl/binary_threshold_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : binary_threshold_pkg                                          |
// | Purpose  : Shared types for the binary threshold pipeline: the 3-bit     |
// |            threshold mode encoding and the frame-counter FSM states.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package binary_threshold_pkg;

  // Mode is a plain 3-bit vector rather than an enum so that the reserved
  // codes 5..7 remain legal values that simply fall through to passthrough.
  typedef logic [2:0] mode_t;

  localparam mode_t MODE_BIN    = 3'd0;
  localparam mode_t MODE_BINV   = 3'd1;
  localparam mode_t MODE_TRUNC  = 3'd2;
  localparam mode_t MODE_TOZERO = 3'd3;
  localparam mode_t MODE_BAND   = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sync_delay_line                                               |
// | Purpose  : DEPTH-stage shift register with asynchronous active-low       |
// |            reset. DEPTH = 0 degenerates to a wire.                       |
// | Ports    : clk  - clock                                                  |
// |            nrst - asynchronous active-low reset (stages cleared to 0)    |
// |            din  - W-bit input word                                       |
// |            dout - din delayed by DEPTH cycles                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sync_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock and reset are not needed for a zero-length line.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ nrst;
      assign dout = din;
    end else begin : g_shift
      logic [W-1:0] stages [DEPTH];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/binary_threshold_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : binary_threshold_pipe                                         |
// | Purpose  : Parametrised pixel binariser with selectable threshold modes, |
// |            band mode, frame-boundary config shadowing and a per-frame    |
// |            foreground pixel counter. Syncs are delayed to match data.    |
// | Ports    : clk, nrst            - pixel clock, async active-low reset    |
// |            cfg_th_lo/hi/mode    - pending config values                  |
// |            cfg_wr               - strobe capturing cfg_* into pending    |
// |            in_gray/hsync/vsync/en - input pixel stream                   |
// |            out_gray/hsync/vsync/en - output stream, LAT cycles later     |
// |            fg_count, fg_valid   - last complete frame's foreground count |
// |                                   and its one-cycle update pulse         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module binary_threshold_pipe
  import binary_threshold_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LAT    = 2,   // legal range 1..4
  parameter int CNT_W  = 22
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] cfg_th_lo,
  input  logic [DATA_W-1:0] cfg_th_hi,
  input  logic [2:0]        cfg_mode,
  input  logic              cfg_wr,
  input  logic [DATA_W-1:0] in_gray,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_en,
  output logic [DATA_W-1:0] out_gray,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_en,
  output logic [CNT_W-1:0]  fg_count,
  output logic              fg_valid
);

  localparam logic [DATA_W-1:0] MAX_VAL   = '1;
  localparam logic [DATA_W-1:0] TH_LO_RST = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam int                PIPE_W    = DATA_W + 4;

  // ---------------------------------------------------------------------
  // Config shadowing: pending registers follow cfg_wr, active registers
  // only change on the input frame-start edge so a frame is never split
  // between two configurations.
  // ---------------------------------------------------------------------
  logic              vsync_d;
  logic              vs_rise;
  logic [DATA_W-1:0] pend_lo, pend_hi, act_lo, act_hi;
  mode_t             pend_mode, act_mode;

  assign vs_rise = in_vsync & ~vsync_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vsync_d   <= 1'b0;
      pend_lo   <= TH_LO_RST;
      pend_hi   <= MAX_VAL;
      pend_mode <= MODE_BIN;
      act_lo    <= TH_LO_RST;
      act_hi    <= MAX_VAL;
      act_mode  <= MODE_BIN;
    end else begin
      vsync_d <= in_vsync;
      if (cfg_wr) begin
        pend_lo   <= cfg_th_lo;
        pend_hi   <= cfg_th_hi;
        pend_mode <= cfg_mode;
      end
      if (vs_rise) begin
        // A write landing on the frame start goes straight to active.
        if (cfg_wr) begin
          act_lo   <= cfg_th_lo;
          act_hi   <= cfg_th_hi;
          act_mode <= cfg_mode;
        end else begin
          act_lo   <= pend_lo;
          act_hi   <= pend_hi;
          act_mode <= pend_mode;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pixel function and foreground flag
  // ---------------------------------------------------------------------
  logic              ge_lo;
  logic              in_band;
  logic [DATA_W-1:0] pix_f;
  logic              flag_f;

  always_comb begin
    ge_lo   = (in_gray >= act_lo);
    // With lo > hi no value can satisfy both bounds, so the band is empty.
    in_band = ge_lo && (in_gray <= act_hi);
    pix_f   = in_gray;
    flag_f  = (in_gray != '0);
    case (act_mode)
      MODE_BIN: begin
        pix_f  = ge_lo ? MAX_VAL : '0;
        flag_f = ge_lo;
      end
      MODE_BINV: begin
        pix_f  = ge_lo ? '0 : MAX_VAL;
        flag_f = ~ge_lo;
      end
      MODE_TRUNC: begin
        pix_f  = ge_lo ? act_lo : in_gray;
        flag_f = ge_lo;
      end
      MODE_TOZERO: begin
        pix_f  = ge_lo ? in_gray : '0;
        flag_f = ge_lo;
      end
      MODE_BAND: begin
        pix_f  = in_band ? MAX_VAL : '0;
        flag_f = in_band;
      end
      default: begin
        // Reserved codes: passthrough, non-zero pixels count as foreground.
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 0 plus LAT-1 matching delay stages for data, flag and syncs
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] s0_gray;
  logic              s0_flag, s0_hs, s0_vs, s0_en;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s0_gray <= '0;
      s0_flag <= 1'b0;
      s0_hs   <= 1'b0;
      s0_vs   <= 1'b0;
      s0_en   <= 1'b0;
    end else begin
      s0_gray <= in_en ? pix_f : '0;
      s0_flag <= in_en & flag_f;
      s0_hs   <= in_hsync;
      s0_vs   <= in_vsync;
      s0_en   <= in_en;
    end
  end

  logic [PIPE_W-1:0] dly_out;
  logic              flag_out;

  sync_delay_line #(
    .W     (PIPE_W),
    .DEPTH (LAT - 1)
  ) u_delay (
    .clk  (clk),
    .nrst (nrst),
    .din  ({s0_hs, s0_vs, s0_en, s0_flag, s0_gray}),
    .dout (dly_out)
  );

  assign {out_hsync, out_vsync, out_en, flag_out, out_gray} = dly_out;

  // ---------------------------------------------------------------------
  // Frame counter on the output side. IDLE swallows the partial frame
  // seen after reset; only frames bounded by two out_vsync rises report.
  // ---------------------------------------------------------------------
  logic             os_d;
  logic             os_rise;
  logic             pix_inc;
  state_e           state;
  logic [CNT_W-1:0] acc;

  assign os_rise = out_vsync & ~os_d;
  assign pix_inc = out_en & flag_out;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      os_d     <= 1'b0;
      state    <= ST_IDLE;
      acc      <= '0;
      fg_count <= '0;
      fg_valid <= 1'b0;
    end else begin
      os_d     <= out_vsync;
      fg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (os_rise) begin
            acc   <= CNT_W'(pix_inc);
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (os_rise) begin
            fg_count <= acc;
            fg_valid <= 1'b1;
            // The pixel coinciding with the frame edge belongs to the new frame.
            acc      <= CNT_W'(pix_inc);
          end else if (pix_inc && (acc != CNT_MAX)) begin
            acc <= acc + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_binary_threshold_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_binary_threshold_pipe                                      |
// | Purpose  : Self-checking bench for binary_threshold_pipe. Three DUTs     |
// |            (LAT=2/CNT_W=22, LAT=1/CNT_W=3, LAT=4/CNT_W=22) share one     |
// |            stimulus stream and are compared against a behavioural model. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_binary_threshold_pipe;

  localparam int MASK = 8191;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] cfg_th_lo = 8'd0, cfg_th_hi = 8'd0;
  logic [2:0] cfg_mode = 3'd0;
  logic       cfg_wr = 1'b0;
  logic [7:0] in_gray = 8'd0;
  logic       in_hsync = 1'b0, in_vsync = 1'b0, in_en = 1'b0;

  logic [7:0]  o2_gray, o1_gray, o4_gray;
  logic        o2_hs, o2_vs, o2_en, fv2;
  logic        o1_hs, o1_vs, o1_en, fv1;
  logic        o4_hs, o4_vs, o4_en, fv4;
  logic [21:0] fc2, fc4;
  logic [2:0]  fc1;

  always #5 clk = ~clk;

  binary_threshold_pipe #(.DATA_W(8), .LAT(2), .CNT_W(22)) dut2 (
    .clk(clk), .nrst(nrst), .cfg_th_lo(cfg_th_lo), .cfg_th_hi(cfg_th_hi),
    .cfg_mode(cfg_mode), .cfg_wr(cfg_wr), .in_gray(in_gray), .in_hsync(in_hsync),
    .in_vsync(in_vsync), .in_en(in_en), .out_gray(o2_gray), .out_hsync(o2_hs),
    .out_vsync(o2_vs), .out_en(o2_en), .fg_count(fc2), .fg_valid(fv2));

  binary_threshold_pipe #(.DATA_W(8), .LAT(1), .CNT_W(3)) dut1 (
    .clk(clk), .nrst(nrst), .cfg_th_lo(cfg_th_lo), .cfg_th_hi(cfg_th_hi),
    .cfg_mode(cfg_mode), .cfg_wr(cfg_wr), .in_gray(in_gray), .in_hsync(in_hsync),
    .in_vsync(in_vsync), .in_en(in_en), .out_gray(o1_gray), .out_hsync(o1_hs),
    .out_vsync(o1_vs), .out_en(o1_en), .fg_count(fc1), .fg_valid(fv1));

  binary_threshold_pipe #(.DATA_W(8), .LAT(4), .CNT_W(22)) dut4 (
    .clk(clk), .nrst(nrst), .cfg_th_lo(cfg_th_lo), .cfg_th_hi(cfg_th_hi),
    .cfg_mode(cfg_mode), .cfg_wr(cfg_wr), .in_gray(in_gray), .in_hsync(in_hsync),
    .in_vsync(in_vsync), .in_en(in_en), .out_gray(o4_gray), .out_hsync(o4_hs),
    .out_vsync(o4_vs), .out_en(o4_en), .fg_count(fc4), .fg_valid(fv4));

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         cyc = 0;
  bit [10:0]  hist [8192];     // {hsync, vsync, en, gray} captured at each edge
  logic [7:0] m_pend_lo, m_pend_hi, m_act_lo, m_act_hi;
  logic [2:0] m_pend_mode, m_act_mode;
  bit         m_prev_vs, m_started;
  int         m_cnt;
  int         exp_rep[$], exp_cyc[$];
  int         got2[$], got1[$], got4[$], gcyc2[$];

  // {flag, value} straight from the mode table.
  function automatic bit [8:0] ref_pix(logic [2:0] mode, logic [7:0] lo, logic [7:0] hi,
                                       logic [7:0] x);
    int xi, l, h, v;
    bit fl;
    xi = int'(x); l = int'(lo); h = int'(hi);
    case (mode)
      3'd0:    begin fl = (xi >= l); v = fl ? 255 : 0; end
      3'd1:    begin fl = (xi < l);  v = fl ? 255 : 0; end
      3'd2:    begin fl = (xi >= l); v = fl ? l : xi; end
      3'd3:    begin fl = (xi >= l); v = fl ? xi : 0; end
      3'd4:    begin fl = (xi >= l) && (xi <= h); v = fl ? 255 : 0; end
      default: begin fl = (xi != 0); v = xi; end
    endcase
    return {fl, v[7:0]};
  endfunction

  function automatic int cap(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Advance one clock: update the model for the coming edge, then collect
  // any fg_valid pulses the DUTs produce.
  task automatic tick();
    bit [8:0] r;
    bit       vr, fg;
    if (!nrst) begin
      for (int k = 0; k < 4; k++) hist[(cyc - k) & MASK] = '0;
      m_pend_lo = 8'd128; m_pend_hi = 8'd255; m_pend_mode = 3'd0;
      m_act_lo  = 8'd128; m_act_hi  = 8'd255; m_act_mode  = 3'd0;
      m_prev_vs = 1'b0; m_started = 1'b0; m_cnt = 0;
    end else begin
      r  = ref_pix(m_act_mode, m_act_lo, m_act_hi, in_gray);
      fg = in_en && r[8];
      hist[cyc & MASK] = {in_hsync, in_vsync, in_en, (in_en ? r[7:0] : 8'd0)};
      vr = in_vsync && !m_prev_vs;
      if (vr) begin
        if (m_started) begin
          exp_rep.push_back(m_cnt);
          exp_cyc.push_back(cyc);
        end
        m_started = 1'b1;
        m_cnt = fg ? 1 : 0;
        if (cfg_wr) begin
          m_act_lo = cfg_th_lo; m_act_hi = cfg_th_hi; m_act_mode = cfg_mode;
        end else begin
          m_act_lo = m_pend_lo; m_act_hi = m_pend_hi; m_act_mode = m_pend_mode;
        end
      end else if (fg) begin
        m_cnt++;
      end
      if (cfg_wr) begin
        m_pend_lo = cfg_th_lo; m_pend_hi = cfg_th_hi; m_pend_mode = cfg_mode;
      end
      m_prev_vs = in_vsync;
    end
    @(posedge clk);
    #1;
    if (fv2) begin got2.push_back(int'(fc2)); gcyc2.push_back(cyc); end
    if (fv1) got1.push_back(int'(fc1));
    if (fv4) got4.push_back(int'(fc4));
    cyc++;
  endtask

  task automatic clear_queues();
    exp_rep.delete(); exp_cyc.delete();
    got2.delete(); got1.delete(); got4.delete(); gcyc2.delete();
  endtask

  task automatic idle_inputs();
    in_en = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; cfg_wr = 1'b0; in_gray = 8'd0;
  endtask

  task automatic flush();
    idle_inputs();
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) tick();
    nrst = 1'b1;
    tick();
    clear_queues();
  endtask

  // Frame start: vsync high for two cycles; optional write on the rising edge.
  task automatic frame_start(input bit wr, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [2:0] mode);
    in_en = 1'b0; in_hsync = 1'b0; in_vsync = 1'b1;
    cfg_wr = wr; cfg_th_lo = lo; cfg_th_hi = hi; cfg_mode = mode;
    tick();
    cfg_wr = 1'b0;
    tick();
    in_vsync = 1'b0;
    tick();
  endtask

  task automatic pixel(input logic [7:0] x, input bit en);
    in_gray = x; in_en = en; in_hsync = 1'b0;
    tick();
  endtask

  // Single pixel then a blank cycle; returns the LAT=2 output for it.
  task automatic feed(input logic [7:0] x, output logic [7:0] y);
    pixel(x, 1'b1);
    pixel(8'd0, 1'b0);
    y = o2_gray;
  endtask

  task automatic mid_write(input logic [7:0] lo, input logic [7:0] hi, input logic [2:0] mode);
    in_en = 1'b0;
    cfg_wr = 1'b1; cfg_th_lo = lo; cfg_th_hi = hi; cfg_mode = mode;
    tick();
    cfg_wr = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({o2_gray, o2_hs, o2_vs, o2_en, fc2, fv2} !== '0)
      begin errors++; $display("FAIL reset_lat2 got=%h required=0", {o2_gray, o2_hs, o2_vs, o2_en, fc2, fv2}); end
    checks++;
    if ({o1_gray, o1_hs, o1_vs, o1_en, fc1, fv1} !== '0)
      begin errors++; $display("FAIL reset_lat1 got=%h required=0", {o1_gray, o1_hs, o1_vs, o1_en, fc1, fv1}); end
    checks++;
    if ({o4_gray, o4_hs, o4_vs, o4_en, fc4, fv4} !== '0)
      begin errors++; $display("FAIL reset_lat4 got=%h required=0", {o4_gray, o4_hs, o4_vs, o4_en, fc4, fv4}); end
  endtask

  task automatic test_bin();
    logic [7:0] xs [4];
    logic [7:0] ex [4];
    xs = '{8'd127, 8'd128, 8'd255, 8'd0};
    ex = '{8'd0, 8'd255, 8'd255, 8'd0};
    frame_start(1'b1, 8'd128, 8'd255, 3'd0);
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin in_gray = xs[j]; in_en = 1'b1; in_hsync = (j == 0); end
      else begin in_gray = 8'd0; in_en = 1'b0; in_hsync = 1'b0; end
      tick();
      if (j >= 1) begin
        checks++;
        if (o2_gray !== ex[j-1] || o2_en !== 1'b1)
          begin errors++; $display("FAIL bin_pix%0d got=%0d/en%b required=%0d/en1", j-1, o2_gray, o2_en, ex[j-1]); end
      end
      checks++;
      if (o2_hs !== (j == 1))
        begin errors++; $display("FAIL bin_hsync_delay step%0d got=%b required=%b", j, o2_hs, (j == 1)); end
    end
  endtask

  task automatic test_shadow();
    logic [7:0] y;
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);          // active stays BIN, L=128
    mid_write(8'd50, 8'd255, 3'd0);
    feed(8'd100, y);
    checks++;
    if (y !== 8'd0) begin errors++; $display("FAIL shadow_hold got=%0d required=0", y); end
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);
    feed(8'd100, y);
    checks++;
    if (y !== 8'd255) begin errors++; $display("FAIL shadow_apply got=%0d required=255", y); end
    mid_write(8'd200, 8'd255, 3'd0);
    feed(8'd100, y);
    checks++;
    if (y !== 8'd255) begin errors++; $display("FAIL shadow_hold2 got=%0d required=255", y); end
    frame_start(1'b1, 8'd150, 8'd255, 3'd0);      // write-through on the frame edge
    feed(8'd170, y);
    checks++;
    if (y !== 8'd255) begin errors++; $display("FAIL writethru_hi got=%0d required=255", y); end
    feed(8'd120, y);
    checks++;
    if (y !== 8'd0) begin errors++; $display("FAIL writethru_lo got=%0d required=0", y); end
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);          // pending also took 150
    feed(8'd170, y);
    checks++;
    if (y !== 8'd255) begin errors++; $display("FAIL writethru_pending got=%0d required=255", y); end
  endtask

  task automatic test_modes();
    logic [2:0] md [6];
    logic [7:0] lo [6];
    logic [7:0] hi [6];
    logic [7:0] ex [18];
    logic [7:0] xs [3];
    logic [7:0] y;
    md = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd1};
    lo = '{8'd100, 8'd100, 8'd100, 8'd200, 8'd100, 8'd100};
    hi = '{8'd150, 8'd150, 8'd150, 8'd100, 8'd150, 8'd150};
    ex = '{8'd10, 8'd100, 8'd100,   8'd0, 8'd100, 8'd200,   8'd0, 8'd255, 8'd0,
           8'd0, 8'd0, 8'd0,        8'd10, 8'd100, 8'd200,  8'd255, 8'd0, 8'd0};
    xs = '{8'd10, 8'd100, 8'd200};
    for (int t = 0; t < 6; t++) begin
      frame_start(1'b1, lo[t], hi[t], md[t]);
      for (int i = 0; i < 3; i++) begin
        feed(xs[i], y);
        checks++;
        if (y !== ex[t*3+i])
          begin errors++; $display("FAIL mode%0d_L%0d_H%0d_x%0d got=%0d required=%0d", md[t], lo[t], hi[t], xs[i], y, ex[t*3+i]); end
      end
    end
  endtask

  task automatic test_frames();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      frame_start(f == 0, 8'd128, 8'd255, 3'd0);
      for (int ln = 0; ln < 4; ln++) begin
        in_en = 1'b0; in_hsync = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
          int p;
          p = ln * 4 + i;
          pixel(((p % 3 == 0) && (p < 15)) ? 8'd200 : 8'(50 + p), 1'b1);
        end
      end
    end
    flush();
    checks++;
    if (got2.size() != 2 || got1.size() != 2 || got4.size() != 2)
      begin errors++; $display("FAIL frames_pulses got=%0d/%0d/%0d required=2/2/2", got2.size(), got1.size(), got4.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got2[i] != 5 || got1[i] != 5 || got4[i] != 5)
          begin errors++; $display("FAIL frames_count%0d got=%0d/%0d/%0d required=5", i, got2[i], got1[i], got4[i]); end
      end
      checks++;
      if (exp_cyc.size() != 2 || gcyc2[0] != exp_cyc[0] + 2 || gcyc2[1] != exp_cyc[1] + 2)
        begin errors++; $display("FAIL frames_pulse_timing got=%0d,%0d", gcyc2[0], gcyc2[1]); end
    end
  endtask

  task automatic test_sat();
    do_reset();
    frame_start(1'b1, 8'd128, 8'd255, 3'd0);
    for (int i = 0; i < 10; i++) begin
      pixel(8'd200, 1'b1);
      if (i > 0) begin
        checks++;
        if (o2_gray !== 8'd0 || o2_en !== 1'b0)
          begin errors++; $display("FAIL blank_pix%0d got=%0d/en%b required=0/en0", i, o2_gray, o2_en); end
      end
      pixel(8'd255, 1'b0);
    end
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);
    flush();
    checks++;
    if (got1.size() != 1 || got1[0] != 7)
      begin errors++; $display("FAIL sat_cnt3 got=%0d (n=%0d) required=7", (got1.size() > 0) ? got1[0] : -1, got1.size()); end
    checks++;
    if (got2.size() != 1 || got2[0] != 10 || got4.size() != 1 || got4[0] != 10)
      begin errors++; $display("FAIL blank_not_counted got=%0d/%0d required=10/10", (got2.size() > 0) ? got2[0] : -1, (got4.size() > 0) ? got4[0] : -1); end
  endtask

  task automatic test_reset_mid();
    frame_start(1'b1, 8'd128, 8'd255, 3'd0);
    for (int i = 0; i < 3; i++) pixel(8'd200, 1'b1);
    nrst = 1'b0;
    #1;
    checks++;
    if ({o2_gray, o2_en, fc2} !== '0 || {o1_gray, o1_en} !== '0 || {o4_gray, o4_en} !== '0)
      begin errors++; $display("FAIL async_clear got=%h/%h/%h required=0", {o2_gray, o2_en, fc2}, {o1_gray, o1_en}, {o4_gray, o4_en}); end
    idle_inputs();
    tick(); tick();
    nrst = 1'b1;
    clear_queues();
    for (int i = 0; i < 2; i++) pixel(8'd200, 1'b1);
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);
    for (int i = 0; i < 4; i++) pixel(8'd200, 1'b1);
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);
    for (int i = 0; i < 6; i++) pixel(8'd200, 1'b1);
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);
    flush();
    checks++;
    if (got2.size() != 2 || got1.size() != 2 || got4.size() != 2)
      begin errors++; $display("FAIL rstmid_pulses got=%0d/%0d/%0d required=2/2/2", got2.size(), got1.size(), got4.size()); end
    else begin
      checks++;
      if (got2[0] != 4 || got1[0] != 4 || got4[0] != 4 || got2[1] != 6 || got1[1] != 6 || got4[1] != 6)
        begin errors++; $display("FAIL rstmid_counts got=%0d,%0d/%0d,%0d/%0d,%0d required=4,6", got2[0], got2[1], got1[0], got1[1], got4[0], got4[1]); end
    end
  endtask

  function automatic logic [7:0] pick_gray(logic [7:0] lo, logic [7:0] hi);
    case ($urandom_range(0, 6))
      0:       return 8'd0;
      1:       return lo;
      2:       return lo - 8'd1;
      3:       return hi;
      4:       return hi + 8'd1;
      5:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    bit [10:0] e;
    flush();
    clear_queues();
    for (int f = 0; f < 6; f++) begin
      frame_start(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      for (int ln = 0; ln < 6; ln++) begin
        in_en = 1'b0; in_hsync = 1'b1; tick();
        in_hsync = 1'b0;
        for (int i = 0; i < 10; i++) begin
          cfg_wr = ($urandom_range(0, 9) == 0);
          cfg_th_lo = 8'($urandom); cfg_th_hi = 8'($urandom); cfg_mode = 3'($urandom_range(0, 7));
          in_en = ($urandom_range(0, 4) != 0);
          in_gray = pick_gray(m_act_lo, m_act_hi);
          tick();
          cfg_wr = 1'b0;
          e = hist[(cyc - 2) & MASK];
          checks++;
          if ({o2_hs, o2_vs, o2_en, o2_gray} !== e)
            begin errors++; $display("FAIL rand_lat2 cyc=%0d got=%h required=%h", cyc, {o2_hs, o2_vs, o2_en, o2_gray}, e); end
          e = hist[(cyc - 1) & MASK];
          checks++;
          if ({o1_hs, o1_vs, o1_en, o1_gray} !== e)
            begin errors++; $display("FAIL rand_lat1 cyc=%0d got=%h required=%h", cyc, {o1_hs, o1_vs, o1_en, o1_gray}, e); end
          e = hist[(cyc - 4) & MASK];
          checks++;
          if ({o4_hs, o4_vs, o4_en, o4_gray} !== e)
            begin errors++; $display("FAIL rand_lat4 cyc=%0d got=%h required=%h", cyc, {o4_hs, o4_vs, o4_en, o4_gray}, e); end
        end
      end
    end
    frame_start(1'b0, 8'd0, 8'd0, 3'd0);
    flush();
    checks++;
    if (got2.size() != exp_rep.size() || got1.size() != exp_rep.size() || got4.size() != exp_rep.size())
      begin errors++; $display("FAIL rand_report_n got=%0d/%0d/%0d required=%0d", got2.size(), got1.size(), got4.size(), exp_rep.size()); end
    else begin
      for (int i = 0; i < exp_rep.size(); i++) begin
        checks++;
        if (got2[i] != exp_rep[i] || got4[i] != exp_rep[i] || got1[i] != cap(exp_rep[i], 7))
          begin errors++; $display("FAIL rand_report%0d got=%0d/%0d/%0d required=%0d/%0d/%0d", i, got2[i], got1[i], got4[i], exp_rep[i], cap(exp_rep[i], 7), exp_rep[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bin();
    test_shadow();
    test_modes();
    test_frames();
    test_sat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
